mat_ops_stream: RTL and testbench
=================================

# mat_ops_stream

Parametrised matrix-operation engine for M10K-backed operands. On `i_start` it reads A (M×K) from memory port A and B from memory port B, then computes either C = A·B (M×N) or C = A + B (elementwise). Results are written row by row to port B at `C_BASE`. It sits between the on-chip M10K banks and the top-level controller. Unlike the fixed 8×8 flow, it supports:
- arbitrary M/N/K,
- configurable memory read latency,
- a mode select,
- row-streamed compute: one C row is buffered at a time instead of whole matrices.

## Interface
- DATA_LEN, 32, element width, signed two's complement
- M, 8, rows of A and C
- N, 8, columns of B and C
- K, 8, columns of A, rows of B
- ADDRESS_SIZE, 5, address width of both ports
- A_BASE, 0, port-A row address of A row 0
- B_BASE, 0, port-B row address of B row 0
- C_BASE, 8, port-B row address of C row 0 (C_BASE+M-1 < 2^ADDRESS_SIZE)
- RD_LAT, 1, memory read latency in cycles (1..3)

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset, asynchronous, active-low
- i_start  in  1  start request, sampled only in IDLE
- i_mode  in  2  00 MUL, 01 ADD, 1x reserved; latched at start
- o_addr_A  out  ADDRESS_SIZE  port-A read address
- i_rdata_A  in  DATA_LEN*K  port-A read row
- o_addr_B  out  ADDRESS_SIZE  port-B read/write address
- o_wr_en_B  out  1  port-B write enable
- i_rdata_B  in  DATA_LEN*N  port-B read row
- o_wdata_B  out  DATA_LEN*N  port-B write row
- o_busy  out  1  high from start acceptance until DONE exits
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  high during DONE when the latched mode was invalid
- o_state  out  3  current top state

## Operation
- Row packing: element j of a row occupies bits [DATA_LEN*j +: DATA_LEN]; row r of X lives at X_BASE+r.
- States and encodings:
  - IDLE 3'b111
  - LOAD_B 3'b000
  - FETCH 3'b001
  - COMPUTE 3'b010
  - WRITE 3'b011
  - DONE 3'b100
- IDLE:
  - i_start=1 with mode MUL → LOAD_B.
  - i_start=1 with mode ADD and K==N → FETCH.
  - Reserved mode, or ADD with K!=N → DONE with o_err=1, and no memory access occurs.
- LOAD_B (MUL only): for k=0..K-1, drive o_addr_B=B_BASE+k and capture i_rdata_B into B buffer row k after RD_LAT cycles. Each row takes 1+RD_LAT cycles and reads are not pipelined. Then → FETCH with r=0.
- FETCH: drive o_addr_A=A_BASE+r. In ADD mode, also drive o_addr_B=B_BASE+r. Capture the row(s) after RD_LAT, hold 1+RD_LAT cycles, then → COMPUTE.
- COMPUTE:
  - MUL: N parallel MACs over K cycles; in cycle k, acc[j] += A[r][k]·B[k][j].
  - ADD: one cycle, acc[j] = A[r][j]+B[r][j].
- WRITE: one cycle with o_wr_en_B=1, o_addr_B=C_BASE+r, o_wdata_B=result row. Then r==M-1 → DONE, else r++ → FETCH.
- DONE: one cycle with o_done=1, o_busy cleared on exit, → IDLE. o_err stays valid only in this cycle.
- Arithmetic: accumulators are 2·DATA_LEN+clog2(K) bits, sign-extended and cleared at COMPUTE entry. The result is reduced to DATA_LEN bits per Configuration.
- i_start outside IDLE is ignored; i_start in the DONE cycle is not queued.
- Address outputs are 0 in states that do not access the corresponding port.

## Timing
- Reset values: state IDLE, o_busy 0, o_done 0, o_err 0, o_wr_en_B 0, o_addr_A 0, o_addr_B 0, o_wdata_B 0, row/k counters 0. Buffers are not cleared.
- Reset mid-operation forces IDLE immediately (asynchronously); o_wr_en_B drops without waiting for a clock.
- Let E0 be the edge sampling i_start. o_done rises on E0+T:
  - MUL: T = K(1+RD_LAT) + M(2+RD_LAT+K). Defaults give 104.
  - ADD: T = M(3+RD_LAT). Defaults give 32.
  - Error: T=0, i.e. DONE is entered at E0.
- o_busy rises on E0 and falls on the edge leaving DONE.
- Memory contract: data for an address driven in cycle t is valid at the end of cycle t+RD_LAT-1+1.

## Configuration
- MAT_OPS_SAT_EN defined: results outside [-2^(DATA_LEN-1), 2^(DATA_LEN-1)-1] clamp to the nearest bound.
- MAT_OPS_SAT_EN undefined: results wrap, i.e. only the low DATA_LEN bits are kept.

## Test plan
- Identity MUL: A=I, B[k][j]=16k+j, mode 00 → C rows at 8..15 equal B; o_done on E0+104; o_wr_en_B high exactly 8 cycles.
- ADD: A[r][j]=r, B[r][j]=1, mode 01 → C[r][j]=r+1 for all r,j; o_done on E0+32; no port-B writes below address 8.
- Overflow MUL: all A,B elements 0x00010000 → every C element 0x00000000 without MAT_OPS_SAT_EN, 0x7FFFFFFF with it.
- Reserved mode 10 → o_done=o_err=1 in the cycle after E0; o_wr_en_B never asserted; o_addr_A/B stay 0.
- Reset mid-MUL: deassert i_rstn during row 3 WRITE → o_wr_en_B=0 immediately, o_state=3'b111. A fresh start then completes in 104 cycles with correct C.
- Start while busy, and RD_LAT=2: pulse i_start at E0+50 → ignored with unchanged timing. With RD_LAT=2, MUL completes at E0+24+96=E0+120.

Source files
------------

// File: rtl/mat_ops_stream.sv
// Row-streamed matrix engine: C = A*B (mode 00) or C = A+B (mode 01); one C row buffered at a time.
// Define MAT_OPS_SAT_EN to clamp results to DATA_LEN signed range instead of wrapping.
module mat_ops_stream #(
   parameter int DATA_LEN     = 32,
   parameter int M            = 8,
   parameter int N            = 8,
   parameter int K            = 8,
   parameter int ADDRESS_SIZE = 5,
   parameter int A_BASE       = 0,
   parameter int B_BASE       = 0,
   parameter int C_BASE       = 8,
   parameter int RD_LAT       = 1
) (
   input  logic                       i_clk,
   input  logic                       i_rstn,
   input  logic                       i_start,
   input  logic [1:0]                 i_mode,
   output logic [ADDRESS_SIZE-1:0]    o_addr_A,
   input  logic [DATA_LEN*K-1:0]      i_rdata_A,
   output logic [ADDRESS_SIZE-1:0]    o_addr_B,
   output logic                       o_wr_en_B,
   input  logic [DATA_LEN*N-1:0]      i_rdata_B,
   output logic [DATA_LEN*N-1:0]      o_wdata_B,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_err,
   output logic [2:0]                 o_state
);

   localparam int ACC_W = 2*DATA_LEN + $clog2(K);
   localparam int KN    = (K > N) ? K : N;
   localparam int RW    = (M > 1) ? $clog2(M) : 1;
   localparam int KW    = (K > 1) ? $clog2(K) : 1;
   localparam logic [RW-1:0] R_LAST = RW'(M-1);
   localparam logic [KW-1:0] K_LAST = KW'(K-1);
   localparam logic [1:0]    C_LAST = 2'(RD_LAT);
`ifdef MAT_OPS_SAT_EN
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_LEN+1){1'b0}}, {(DATA_LEN-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_LEN+1){1'b1}}, {(DATA_LEN-1){1'b0}}};
`endif

   typedef enum logic [2:0] {
      IDLE    = 3'b111,
      LOAD_B  = 3'b000,
      FETCH   = 3'b001,
      COMPUTE = 3'b010,
      WRITE   = 3'b011,
      DONE    = 3'b100
   } state_t;

   state_t                     state, state_nxt;
   logic [1:0]                 mode_q;
   logic                       err_q;
   logic [RW-1:0]              row;
   logic [KW-1:0]              kk;
   logic [1:0]                 lat;
   logic                       lat_done, mode_mul;
   logic [DATA_LEN*N-1:0]      b_buf [K];
   logic [DATA_LEN*KN-1:0]     a_row;
   logic signed [ACC_W-1:0]    acc     [N];
   logic signed [ACC_W-1:0]    mac_nxt [N];
   logic signed [ACC_W-1:0]    add_nxt [N];
   logic signed [2*DATA_LEN-1:0] a_el, b_el, prod;

   assign lat_done = (lat == C_LAST);
   assign mode_mul = (mode_q == 2'b00);
   assign o_state  = state;

   function automatic logic [DATA_LEN-1:0] reduce(input logic signed [ACC_W-1:0] v);
`ifdef MAT_OPS_SAT_EN
      if (v > SAT_MAX)      return SAT_MAX[DATA_LEN-1:0];
      else if (v < SAT_MIN) return SAT_MIN[DATA_LEN-1:0];
      else                  return v[DATA_LEN-1:0];
`else
      return v[DATA_LEN-1:0];
`endif
   endfunction

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      o_addr_A  = '0;
      o_addr_B  = '0;
      o_wr_en_B = 1'b0;
      o_done    = 1'b0;
      o_err     = 1'b0;
      o_busy    = (state != IDLE);
      case (state)
         IDLE: begin
            if (i_start) begin
               if (i_mode == 2'b00)                 state_nxt = LOAD_B;
               else if (i_mode == 2'b01 && K == N)  state_nxt = FETCH;
               else                                 state_nxt = DONE;
            end
         end
         LOAD_B: begin
            o_addr_B = ADDRESS_SIZE'(B_BASE) + ADDRESS_SIZE'(kk);
            if (lat_done && kk == K_LAST) state_nxt = FETCH;
         end
         FETCH: begin
            o_addr_A = ADDRESS_SIZE'(A_BASE) + ADDRESS_SIZE'(row);
            if (!mode_mul) o_addr_B = ADDRESS_SIZE'(B_BASE) + ADDRESS_SIZE'(row);
            if (lat_done) state_nxt = COMPUTE;
         end
         COMPUTE: begin
            if (!mode_mul || kk == K_LAST) state_nxt = WRITE;
         end
         WRITE: begin
            o_wr_en_B = 1'b1;
            o_addr_B  = ADDRESS_SIZE'(C_BASE) + ADDRESS_SIZE'(row);
            state_nxt = (row == R_LAST) ? DONE : FETCH;
         end
         DONE: begin
            o_done    = 1'b1;
            o_err     = err_q;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Products are formed at full width so the accumulator never loses sign or magnitude
   always_comb begin
      a_el = (2*DATA_LEN)'($signed(a_row[DATA_LEN*kk +: DATA_LEN]));
      b_el = '0;
      prod = '0;
      for (int j = 0; j < N; j++) begin
         b_el       = (2*DATA_LEN)'($signed(b_buf[kk][DATA_LEN*j +: DATA_LEN]));
         prod       = a_el * b_el;
         mac_nxt[j] = acc[j] + ACC_W'(prod);
         add_nxt[j] = ACC_W'($signed(a_row[DATA_LEN*j +: DATA_LEN]))
                    + ACC_W'($signed(b_buf[0][DATA_LEN*j +: DATA_LEN]));
      end
   end

   always_comb begin
      o_wdata_B = '0;
      if (state == WRITE) begin
         for (int j = 0; j < N; j++) o_wdata_B[DATA_LEN*j +: DATA_LEN] = reduce(acc[j]);
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         mode_q <= 2'b00;
         err_q  <= 1'b0;
         row    <= '0;
         kk     <= '0;
         lat    <= '0;
         for (int j = 0; j < N; j++) acc[j] <= '0;
      end else begin
         case (state)
            IDLE: begin
               row <= '0;
               kk  <= '0;
               lat <= '0;
               if (i_start) begin
                  mode_q <= i_mode;
                  err_q  <= !(i_mode == 2'b00 || (i_mode == 2'b01 && K == N));
               end
            end
            LOAD_B: begin
               if (lat_done) begin
                  lat <= '0;
                  kk  <= (kk == K_LAST) ? '0 : kk + KW'(1);
               end else begin
                  lat <= lat + 2'd1;
               end
            end
            FETCH: begin
               if (lat_done) begin
                  lat <= '0;
                  for (int j = 0; j < N; j++) acc[j] <= '0;
               end else begin
                  lat <= lat + 2'd1;
               end
            end
            COMPUTE: begin
               for (int j = 0; j < N; j++) acc[j] <= mode_mul ? mac_nxt[j] : add_nxt[j];
               if (mode_mul) kk <= (kk == K_LAST) ? '0 : kk + KW'(1);
            end
            WRITE: row <= (row == R_LAST) ? '0 : row + RW'(1);
            default: ;
         endcase
      end
   end

   // Operand buffers carry no reset; they are always written before being read
   always_ff @(posedge i_clk) begin
      if (state == LOAD_B && lat_done) b_buf[kk] <= i_rdata_B;
      if (state == FETCH && lat_done) begin
         a_row <= (DATA_LEN*KN)'(i_rdata_A);
         if (!mode_mul) b_buf[0] <= i_rdata_B;
      end
   end

endmodule

// File: tb/tb_mat_ops_stream.sv
// Bench for mat_ops_stream: two instances (RD_LAT 1 and 2) sharing behavioural memories.
module tb_mat_ops_stream;
   localparam int DL = 32, M = 8, N = 8, K = 8, AS = 5;
   localparam int A_BASE = 0, B_BASE = 0, C_BASE = 8;
   localparam int T_MUL1 = K*(1+1) + M*(2+1+K);
   localparam int T_MUL2 = K*(1+2) + M*(2+2+K);
   localparam int T_ADD1 = M*(3+1);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rstn, start1, start2, clr;
   logic [1:0]    mode;
   logic [AS-1:0] addr_A1, addr_B1, addr_A2, addr_B2;
   logic [DL*K-1:0] rdata_A1, rdata_A2;
   logic [DL*N-1:0] rdata_B1, rdata_B2, wdata1, wdata2;
   logic          wr1, wr2, busy1, busy2, done1, done2, err1, err2;
   logic [2:0]    st1, st2;

   logic [DL*K-1:0] mem_A [32];
   logic [DL*N-1:0] mem_B [32];
   logic [DL*N-1:0] mem_C [32];
   logic [AS-1:0]   pa1, pb1;
   logic [AS-1:0]   pa2 [2];
   logic [AS-1:0]   pb2 [2];
   int              wr_cnt, low_wr;
   int              vectors = 0, errors = 0;

   mat_ops_stream #(.DATA_LEN(DL), .M(M), .N(N), .K(K), .ADDRESS_SIZE(AS), .A_BASE(A_BASE),
                    .B_BASE(B_BASE), .C_BASE(C_BASE), .RD_LAT(1)) dut (
      .i_clk(clk), .i_rstn(rstn), .i_start(start1), .i_mode(mode),
      .o_addr_A(addr_A1), .i_rdata_A(rdata_A1), .o_addr_B(addr_B1), .o_wr_en_B(wr1),
      .i_rdata_B(rdata_B1), .o_wdata_B(wdata1), .o_busy(busy1), .o_done(done1),
      .o_err(err1), .o_state(st1));

   mat_ops_stream #(.DATA_LEN(DL), .M(M), .N(N), .K(K), .ADDRESS_SIZE(AS), .A_BASE(A_BASE),
                    .B_BASE(B_BASE), .C_BASE(C_BASE), .RD_LAT(2)) dut_lat2 (
      .i_clk(clk), .i_rstn(rstn), .i_start(start2), .i_mode(mode),
      .o_addr_A(addr_A2), .i_rdata_A(rdata_A2), .o_addr_B(addr_B2), .o_wr_en_B(wr2),
      .i_rdata_B(rdata_B2), .o_wdata_B(wdata2), .o_busy(busy2), .o_done(done2),
      .o_err(err2), .o_state(st2));

   // Read ports: address registered through RD_LAT stages
   always @(posedge clk) begin
      pa1    <= addr_A1;
      pb1    <= addr_B1;
      pa2[0] <= addr_A2;
      pa2[1] <= pa2[0];
      pb2[0] <= addr_B2;
      pb2[1] <= pb2[0];
   end
   assign rdata_A1 = mem_A[pa1];
   assign rdata_B1 = mem_B[pb1];
   assign rdata_A2 = mem_A[pa2[1]];
   assign rdata_B2 = mem_B[pb2[1]];

   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 32; i++) mem_C[i] <= '0;
         wr_cnt <= 0;
         low_wr <= 0;
      end else if (wr1 || wr2) begin
         mem_C[wr1 ? addr_B1 : addr_B2] <= wr1 ? wdata1 : wdata2;
         wr_cnt <= wr_cnt + 1;
         if ((wr1 ? addr_B1 : addr_B2) < AS'(C_BASE)) low_wr <= low_wr + 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic fill(input int kind);
      for (int r = 0; r < 32; r++) begin
         for (int j = 0; j < K; j++) begin
            case (kind)
               0:       mem_A[r][DL*j +: DL] = (r == j) ? 32'd1 : 32'd0;
               1:       mem_A[r][DL*j +: DL] = 32'(r);
               2:       mem_A[r][DL*j +: DL] = 32'h0001_0000;
               default: mem_A[r][DL*j +: DL] = $urandom;
            endcase
         end
         for (int j = 0; j < N; j++) begin
            case (kind)
               0:       mem_B[r][DL*j +: DL] = 32'(16*r + j);
               1:       mem_B[r][DL*j +: DL] = 32'd1;
               2:       mem_B[r][DL*j +: DL] = 32'h0001_0000;
               default: mem_B[r][DL*j +: DL] = $urandom;
            endcase
         end
      end
   endtask

   // Exact-sum model of one C element, then wrap or clamp to DL bits
   function automatic logic [DL-1:0] ref_el(input logic [1:0] md, input int r, input int j);
      logic signed [127:0] s, a, b;
      s = '0;
      if (md == 2'b00) begin
         for (int k = 0; k < K; k++) begin
            a = 128'($signed(mem_A[A_BASE+r][DL*k +: DL]));
            b = 128'($signed(mem_B[B_BASE+k][DL*j +: DL]));
            s = s + a * b;
         end
      end else begin
         a = 128'($signed(mem_A[A_BASE+r][DL*j +: DL]));
         b = 128'($signed(mem_B[B_BASE+r][DL*j +: DL]));
         s = a + b;
      end
`ifdef MAT_OPS_SAT_EN
      if (s > 128'sd2147483647)       return 32'h7FFF_FFFF;
      else if (s < -128'sd2147483648) return 32'h8000_0000;
`endif
      return s[DL-1:0];
   endfunction

   task automatic clear_log();
      clr = 1'b1;
      @(posedge clk);
      #1 clr = 1'b0;
   endtask

   task automatic run(input int which, input logic [1:0] md, input int poke, output int t);
      @(negedge clk);
      mode = md;
      if (which == 1) start1 = 1'b1; else start2 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      start2 = 1'b0;
      t = 0;
      while (!((which == 1) ? done1 : done2) && t < 1000) begin
         if (poke > 0 && t == poke - 1) begin
            if (which == 1) start1 = 1'b1; else start2 = 1'b1;
         end
         @(posedge clk);
         #1;
         t++;
         start1 = 1'b0;
         start2 = 1'b0;
      end
   endtask

   task automatic check_c(input string tag, input logic [1:0] md);
      for (int r = 0; r < M; r++)
         for (int j = 0; j < N; j++)
            check($sformatf("%s C[%0d][%0d]", tag, r, j), 64'(mem_C[C_BASE+r][DL*j +: DL]),
                  64'(ref_el(md, r, j)));
   endtask

   task automatic check_after(input string tag, input int which);
      @(posedge clk);
      #1;
      check({tag, " done_drop"}, (which == 1) ? done1 : done2, 1'b0);
      check({tag, " busy_drop"}, (which == 1) ? busy1 : busy2, 1'b0);
      check({tag, " idle"}, (which == 1) ? st1 : st2, 3'b111);
   endtask

   task automatic mul_case(input string tag, input int which, input int kind, input int poke);
      int t;
      fill(kind);
      clear_log();
      run(which, 2'b00, poke, t);
      check({tag, " T"}, 64'(t), 64'((which == 1) ? T_MUL1 : T_MUL2));
      check({tag, " busy_at_done"}, (which == 1) ? busy1 : busy2, 1'b1);
      check({tag, " writes"}, 64'(wr_cnt), 64'(M));
      check_c(tag, 2'b00);
      check_after(tag, which);
   endtask

   initial begin
      int t, n, guard;
      rstn = 1'b0; start1 = 1'b0; start2 = 1'b0; mode = 2'b00; clr = 1'b0;
      #12;
      check("rst state", st1, 3'b111);
      check("rst busy", busy1, 1'b0);
      check("rst done", done1, 1'b0);
      check("rst err", err1, 1'b0);
      check("rst wr_en", wr1, 1'b0);
      check("rst addr_A", addr_A1, 0);
      check("rst addr_B", addr_B1, 0);
      check("rst wdata", 64'(|wdata1), 0);
      check("rst state lat2", st2, 3'b111);
      @(negedge clk) rstn = 1'b1;

      mul_case("identity", 1, 0, 0);
      check("identity C[3][5]", 64'(mem_C[C_BASE+3][DL*5 +: DL]), 64'(16*3 + 5));

      fill(1);
      clear_log();
      run(1, 2'b01, 0, t);
      check("add T", 64'(t), 64'(T_ADD1));
      check("add writes", 64'(wr_cnt), 64'(M));
      check("add low writes", 64'(low_wr), 0);
      check("add C[6][2]", 64'(mem_C[C_BASE+6][DL*2 +: DL]), 64'd7);
      check_c("add", 2'b01);
      check_after("add", 1);

      mul_case("overflow", 1, 2, 0);
      mul_case("rand_mul", 1, 3, 0);
      mul_case("rand_mul2", 1, 3, 0);

      fill(3);
      clear_log();
      run(1, 2'b01, 0, t);
      check("rand_add T", 64'(t), 64'(T_ADD1));
      check_c("rand_add", 2'b01);

      for (int m = 2; m < 4; m++) begin
         clear_log();
         run(1, 2'(m), 0, t);
         check("rsv T", 64'(t), 0);
         check("rsv err", err1, 1'b1);
         check("rsv state", st1, 3'b100);
         check("rsv addr_A", addr_A1, 0);
         check("rsv addr_B", addr_B1, 0);
         @(posedge clk);
         #1;
         check("rsv err_drop", err1, 1'b0);
         check("rsv writes", 64'(wr_cnt), 0);
      end

      // Reset asserted during the row-3 write
      fill(0);
      clear_log();
      @(negedge clk);
      mode = 2'b00;
      start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      n = 0;
      guard = 0;
      while (n < 4 && guard < 500) begin
         @(posedge clk);
         #1;
         guard++;
         if (wr1) n++;
      end
      check("rst_mid reached row3", 64'(n), 64'd4);
      #1 rstn = 1'b0;
      #1;
      check("rst_mid wr_en", wr1, 1'b0);
      check("rst_mid state", st1, 3'b111);
      check("rst_mid busy", busy1, 1'b0);
      @(negedge clk) rstn = 1'b1;
      mul_case("after_rst", 1, 0, 0);

      mul_case("start_busy", 1, 3, 50);
      mul_case("lat2", 2, 3, 0);
      mul_case("lat2_busy", 2, 0, 50);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
